// File: rtl/instr_encoder.sv
// instr_encoder: registered RV32I instruction encoder with a one-deep valid/ready output stage.
// Build option: define INSTR_ENC_CTRLFLOW_EN to encode BRANCH, JAL and JALR (otherwise they are illegal).
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [3:0]  in_alu_op,
  input  logic [2:0]  in_f3,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] enc_count,
  output logic [7:0]  err_count
);

  localparam logic [3:0] KIND_R      = 4'd0;
  localparam logic [3:0] KIND_IALU   = 4'd1;
  localparam logic [3:0] KIND_LOAD   = 4'd2;
  localparam logic [3:0] KIND_STORE  = 4'd3;
  localparam logic [3:0] KIND_BRANCH = 4'd4;
  localparam logic [3:0] KIND_JAL    = 4'd5;
  localparam logic [3:0] KIND_JALR   = 4'd6;
  localparam logic [3:0] KIND_LUI    = 4'd7;
  localparam logic [3:0] KIND_AUIPC  = 4'd8;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_SUB = 4'b0001;

  function automatic logic fits_simm12(input logic [31:0] imm);
    return (imm[31:11] == 21'h000000) || (imm[31:11] == 21'h1FFFFF);
  endfunction

`ifdef INSTR_ENC_CTRLFLOW_EN
  function automatic logic fits_bimm(input logic [31:0] imm);
    return ((imm[31:12] == 20'h00000) || (imm[31:12] == 20'hFFFFF)) && (imm[0] == 1'b0);
  endfunction

  function automatic logic fits_jimm(input logic [31:0] imm);
    return ((imm[31:20] == 12'h000) || (imm[31:20] == 12'hFFF)) && (imm[0] == 1'b0);
  endfunction
`else
  logic ctrl_unused_s;
  assign ctrl_unused_s = ^in_f3;
`endif

  logic        alu_bad_s;
  logic        is_shift_s;
  logic [2:0]  alu_f3_s;
  logic [6:0]  alu_f7_s;
  logic [31:0] raw_instr_s;
  logic [31:0] enc_instr_s;
  logic        enc_err_s;
  logic        accept_s;
  logic        xfer_s;

  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept_s = in_valid && in_ready;
  assign xfer_s   = out_valid && out_ready;

  // ALU operation to funct3/funct7 translation.
  always_comb begin
    alu_bad_s  = 1'b0;
    is_shift_s = 1'b0;
    alu_f3_s   = 3'b000;
    alu_f7_s   = 7'h00;
    case (in_alu_op)
      4'b0000: alu_f3_s = 3'b000;
      4'b0001: begin alu_f3_s = 3'b000; alu_f7_s = 7'h20; end
      4'b0010: alu_f3_s = 3'b111;
      4'b0011: alu_f3_s = 3'b110;
      4'b0100: alu_f3_s = 3'b100;
      4'b0101: begin alu_f3_s = 3'b001; is_shift_s = 1'b1; end
      4'b0110: begin alu_f3_s = 3'b101; is_shift_s = 1'b1; end
      4'b0111: begin alu_f3_s = 3'b101; alu_f7_s = 7'h20; is_shift_s = 1'b1; end
      4'b1000: alu_f3_s = 3'b010;
      4'b1001: alu_f3_s = 3'b011;
      default: alu_bad_s = 1'b1;
    endcase
  end

  // Instruction word assembly and legality checks for the presented request.
  always_comb begin
    raw_instr_s = 32'h0000_0000;
    enc_err_s   = 1'b0;
    case (in_kind)
      KIND_R: begin
        if (alu_bad_s) begin
          enc_err_s = 1'b1;
        end else begin
          raw_instr_s = {alu_f7_s, in_rs2, in_rs1, alu_f3_s, in_rd, OP_R};
        end
      end
      KIND_IALU: begin
        if (alu_bad_s || (in_alu_op == ALU_SUB)) begin
          enc_err_s = 1'b1;
        end else if (is_shift_s) begin
          // Shifts carry funct7 in the upper immediate bits, so only a 5-bit amount is legal.
          if (in_imm[31:5] != 27'h0) begin
            enc_err_s = 1'b1;
          end else begin
            raw_instr_s = {alu_f7_s, in_imm[4:0], in_rs1, alu_f3_s, in_rd, OP_IALU};
          end
        end else if (!fits_simm12(in_imm)) begin
          enc_err_s = 1'b1;
        end else begin
          raw_instr_s = {in_imm[11:0], in_rs1, alu_f3_s, in_rd, OP_IALU};
        end
      end
      KIND_LOAD: begin
        if (!fits_simm12(in_imm)) begin
          enc_err_s = 1'b1;
        end else begin
          raw_instr_s = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LOAD};
        end
      end
      KIND_STORE: begin
        if (!fits_simm12(in_imm)) begin
          enc_err_s = 1'b1;
        end else begin
          raw_instr_s = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_STORE};
        end
      end
`ifdef INSTR_ENC_CTRLFLOW_EN
      KIND_BRANCH: begin
        if (!fits_bimm(in_imm) || (in_f3 == 3'b010) || (in_f3 == 3'b011)) begin
          enc_err_s = 1'b1;
        end else begin
          raw_instr_s = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_f3,
                         in_imm[4:1], in_imm[11], OP_BRANCH};
        end
      end
      KIND_JAL: begin
        if (!fits_jimm(in_imm)) begin
          enc_err_s = 1'b1;
        end else begin
          raw_instr_s = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
        end
      end
      KIND_JALR: begin
        if (!fits_simm12(in_imm)) begin
          enc_err_s = 1'b1;
        end else begin
          raw_instr_s = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
        end
      end
`endif
      KIND_LUI:   raw_instr_s = {in_imm[31:12], in_rd, OP_LUI};
      KIND_AUIPC: raw_instr_s = {in_imm[31:12], in_rd, OP_AUIPC};
      default:    enc_err_s = 1'b1;
    endcase
  end

  assign enc_instr_s = enc_err_s ? 32'h0000_0000 : raw_instr_s;

  // Output stage: load on accept, empty after an unreplaced transfer, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= 32'h0000_0000;
      out_err   <= 1'b0;
    end else if (accept_s) begin
      out_valid <= 1'b1;
      out_instr <= enc_instr_s;
      out_err   <= enc_err_s;
    end else if (xfer_s) begin
      out_valid <= 1'b0;
    end
  end

  // Transfer statistics: legal words wrap, illegal words saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_count <= 16'd0;
      err_count <= 8'd0;
    end else if (xfer_s) begin
      if (!out_err) begin
        enc_count <= enc_count + 16'd1;
      end else if (err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder with hand-encoded reference words.
// Control-flow expectations follow INSTR_ENC_CTRLFLOW_EN when defined.
module tb_instr_encoder;

  typedef struct packed {
    logic [3:0]  kind;
    logic [3:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        err;
    logic [31:0] instr;
  } vec_t;

  localparam logic [3:0] K_R = 4'd0, K_I = 4'd1, K_LD = 4'd2, K_ST = 4'd3, K_BR = 4'd4;
  localparam logic [3:0] K_JAL = 4'd5, K_JALR = 4'd6, K_LUI = 4'd7, K_AUIPC = 4'd8;
`ifdef INSTR_ENC_CTRLFLOW_EN
  localparam bit CF = 1'b1;
`else
  localparam bit CF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [3:0]  in_alu_op;
  logic [2:0]  in_f3;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  instr_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_alu_op(in_alu_op), .in_f3(in_f3),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .enc_count(enc_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_miss;
  logic [32:0] sb[$];
  logic [32:0] cur_exp;
  logic [15:0] exp_enc;
  logic [7:0]  exp_errc;
  vec_t        tbl[$];

  task automatic chk_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] kind, input logic [3:0] op, input logic [2:0] f3,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic err, input logic [31:0] instr);
    vec_t v;
    v.kind = kind; v.op = op; v.f3 = f3; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.err = err; v.instr = instr;
    return v;
  endfunction

  function automatic vec_t mk_cf(input logic [3:0] kind, input logic [2:0] f3, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                                 input logic err, input logic [31:0] instr);
    return mk(kind, 4'd0, f3, rd, rs1, rs2, imm, CF ? err : 1'b1, CF ? instr : 32'h0);
  endfunction

  task automatic set_in(input vec_t v);
    in_kind = v.kind; in_alu_op = v.op; in_f3 = v.f3;
    in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
    cur_exp = {v.err, v.instr};
  endtask

  // One clock: observe handshakes mid-cycle, then return 1 time unit after the edge.
  task automatic tick(output bit acc);
    logic [32:0] e;
    acc = 1'b0;
    @(negedge clk);
    if (!rst) begin
      chk_vec("enc_count", enc_count, exp_enc);
      chk_vec("err_count", err_count, exp_errc);
      if (out_valid && out_ready) begin
        chk_vec("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk_vec("word", {out_err, out_instr}, e);
          if (e[32]) begin
            if (exp_errc != 8'hFF) exp_errc = exp_errc + 8'd1;
          end else begin
            exp_enc = exp_enc + 16'd1;
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(cur_exp);
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input bit rand_ready);
    bit acc;
    int waited;
    set_in(v);
    in_valid = 1'b1;
    acc = 1'b0;
    waited = 0;
    while (!acc && waited < 32) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick(acc);
      waited++;
    end
    chk_vec("accept_bound", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 16) begin
      tick(acc);
      n++;
    end
    chk_vec("drain_empty", sb.size(), 0);
  endtask

  task automatic clear_model();
    sb.delete();
    exp_enc = 16'd0;
    exp_errc = 8'd0;
  endtask

  task automatic do_reset();
    bit acc;
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    set_in(tbl[0]);
    tick(acc);
    tick(acc);
    chk_vec("rst_in_ready", in_ready, 0);
    chk_vec("rst_out_valid", out_valid, 0);
    chk_vec("rst_out_instr", out_instr, 0);
    chk_vec("rst_out_err", out_err, 0);
    chk_vec("rst_enc_count", enc_count, 0);
    chk_vec("rst_err_count", err_count, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    clear_model();
    tick(acc);
    chk_vec("post_rst_in_ready", in_ready, 1);
  endtask

  initial begin
    bit acc;
    vec_t va;
    vec_t vb;
    n_vec = 0;
    n_miss = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_kind = 4'd0; in_alu_op = 4'd0; in_f3 = 3'd0;
    in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'h0;
    cur_exp = 33'h0;
    clear_model();

    tbl.push_back(mk(K_R,  4'b0000, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 32'h002081B3));
    tbl.push_back(mk(K_R,  4'b0001, 3'd0, 5'd5, 5'd6, 5'd7, 32'h0, 1'b0, 32'h407302B3));
    tbl.push_back(mk(K_I,  4'b0000, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 32'hFFF00093));
    tbl.push_back(mk(K_LD, 4'b0000, 3'd0, 5'd4, 5'd2, 5'd0, 32'd8, 1'b0, 32'h00812203));
    tbl.push_back(mk(K_I,  4'b0000, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 32'h0));
    tbl.push_back(mk(K_ST, 4'b0000, 3'd0, 5'd0, 5'd2, 5'd3, 32'hFFFFFFFC, 1'b0, 32'hFE312E23));
    tbl.push_back(mk(K_LUI, 4'b0000, 3'd0, 5'd10, 5'd0, 5'd0, 32'h12345ABC, 1'b0, 32'h12345537));
    tbl.push_back(mk(K_AUIPC, 4'b0000, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFF000, 1'b0, 32'hFFFFF097));
    tbl.push_back(mk(K_I,  4'b0111, 3'd0, 5'd2, 5'd3, 5'd0, 32'd5, 1'b0, 32'h4051D113));
    tbl.push_back(mk(K_I,  4'b0101, 3'd0, 5'd2, 5'd3, 5'd0, 32'd32, 1'b1, 32'h0));
    tbl.push_back(mk(K_I,  4'b0001, 3'd0, 5'd2, 5'd3, 5'd0, 32'd1, 1'b1, 32'h0));
    tbl.push_back(mk(4'd9, 4'b0000, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1, 32'h0));
    tbl.push_back(mk(K_R,  4'b1010, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 32'h0));
    tbl.push_back(mk(K_I,  4'b0000, 3'd0, 5'd1, 5'd1, 5'd0, 32'hFFFFF800, 1'b0, 32'h80008093));
    tbl.push_back(mk(K_I,  4'b0000, 3'd0, 5'd1, 5'd1, 5'd0, 32'hFFFFF7FF, 1'b1, 32'h0));
    tbl.push_back(mk(K_I,  4'b0000, 3'd0, 5'd1, 5'd1, 5'd0, 32'd2047, 1'b0, 32'h7FF08093));
    tbl.push_back(mk(K_R,  4'b1001, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 32'h003130B3));
    tbl.push_back(mk_cf(K_BR, 3'b000, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h00208463));
    tbl.push_back(mk_cf(K_BR, 3'b000, 5'd0, 5'd1, 5'd2, 32'd7, 1'b1, 32'h0));
    tbl.push_back(mk_cf(K_BR, 3'b010, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0));
    tbl.push_back(mk_cf(K_BR, 3'b000, 5'd0, 5'd1, 5'd2, 32'hFFFFF000, 1'b0, 32'h80208063));
    tbl.push_back(mk_cf(K_BR, 3'b000, 5'd0, 5'd1, 5'd2, 32'd4096, 1'b1, 32'h0));
    tbl.push_back(mk_cf(K_JAL, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h001000EF));
    tbl.push_back(mk_cf(K_JALR, 3'b000, 5'd1, 5'd5, 5'd0, 32'd4, 1'b0, 32'h004280E7));

    // Directed pass at full throughput, then the same words under random backpressure.
    do_reset();
    foreach (tbl[i]) apply(tbl[i], 1'b0);
    drain();
    foreach (tbl[i]) apply(tbl[i], 1'b1);
    drain();

    // A lone out-of-range I immediate is reported and counted once.
    do_reset();
    apply(tbl[4], 1'b0);
    drain();
    chk_vec("illegal_err_count", err_count, 1);

    // Three stalled cycles, then two words drain in two cycles.
    do_reset();
    va = tbl[0];
    vb = tbl[1];
    out_ready = 1'b0;
    apply(va, 1'b0);
    set_in(vb);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_vec("bp_in_ready", in_ready, 0);
      chk_vec("bp_hold", {out_err, out_instr}, {1'b0, va.instr});
      tick(acc);
    end
    out_ready = 1'b1;
    tick(acc);
    chk_vec("bp_accept_on_release", acc, 1);
    in_valid = 1'b0;
    tick(acc);
    chk_vec("bp_enc_count", enc_count, 2);
    chk_vec("bp_out_valid", out_valid, 0);

    // Reset while a word is stalled discards it uncounted.
    do_reset();
    out_ready = 1'b0;
    apply(va, 1'b0);
    tick(acc);
    chk_vec("stall_valid", out_valid, 1);
    rst = 1'b1;
    tick(acc);
    chk_vec("rst_stall_valid", out_valid, 0);
    chk_vec("rst_stall_enc", enc_count, 0);
    rst = 1'b0;
    clear_model();
    out_ready = 1'b1;
    tick(acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: the request fields are valid.
REQ-004 SHALL have port in_ready, output, 1 bit: the encoder can accept a request.
REQ-005 SHALL have port in_kind, input, 4 bits: instruction class. 0=R, 1=I-ALU, 2=LOAD, 3=STORE, 4=BRANCH, 5=JAL, 6=JALR, 7=LUI, 8=AUIPC; 9-15 are illegal.
REQ-006 SHALL have port in_alu_op, input, 4 bits: ALU operation, using the datapath alu_op coding.
REQ-007 SHALL have port in_f3, input, 3 bits: branch condition; used only when in_kind=BRANCH.
REQ-008 SHALL have ports in_rd, in_rs1 and in_rs2, input, 5 bits each: register indices.
REQ-009 SHALL have port in_imm, input, 32 bits: signed byte-offset or value immediate.
REQ-010 SHALL have port out_valid, output, 1 bit: an encoded word is present.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream stage accepts the word.
REQ-012 SHALL have port out_instr, output, 32 bits: the encoded RV32I instruction word.
REQ-013 SHALL have port out_err, output, 1 bit: the request accompanying this word was illegal.
REQ-014 SHALL have port enc_count, output, 16 bits: count of legal words transferred; wraps.
REQ-015 SHALL have port err_count, output, 8 bits: count of illegal words transferred; saturates at 255.

Function
REQ-016 SHALL register its output with 1-cycle latency: a request accepted at edge N is presented on out_* from edge N onward.
REQ-017 SHALL drive in_ready = !out_valid || out_ready, so that back-to-back transfers sustain one word per cycle.
REQ-018 SHALL accept a request when in_valid && in_ready, and SHALL transfer the output word when out_valid && out_ready.
REQ-019 SHALL clear out_valid after a transfer with no new accept, and SHALL keep out_valid set on a simultaneous transfer and accept.
REQ-020 SHALL hold out_instr and out_err stable while out_valid && !out_ready.
REQ-021 SHALL map alu_op to funct3/funct7 as follows:
- 0000 ADD = 000/00
- 0001 SUB = 000/20
- 0010 AND = 111/00
- 0011 OR = 110/00
- 0100 XOR = 100/00
- 0101 SLL = 001/00
- 0110 SRL = 101/00
- 0111 SRA = 101/20
- 1000 SLT = 010/00
- 1001 SLTU = 011/00
- 1010-1111 = illegal
REQ-022 SHALL treat SUB as illegal for I-ALU.
REQ-023 SHALL require, for the I-ALU shifts (SLL, SRL, SRA), in_imm[31:5]=0, and SHALL place funct7 in bits [31:25].
REQ-024 SHALL use opcodes R=0110011, I-ALU=0010011, LOAD=0000011 (funct3 010), STORE=0100011 (funct3 010), BRANCH=1100011, JAL=1101111, JALR=1100111 (funct3 000), LUI=0110111 and AUIPC=0010111.
REQ-025 SHALL require the I/S immediate to lie within -2048..2047.
REQ-026 SHALL require the B immediate to lie within -4096..4094 with bit0=0.
REQ-027 SHALL require the J immediate to lie within -1048576..1048574 with bit0=0.
REQ-028 SHALL use in_imm[31:12] for U-type and ignore in_imm[11:0].
REQ-029 SHALL treat BRANCH with in_f3 = 010 or 011 as illegal.
REQ-030 SHALL, for any illegal request, output out_instr=32'h00000000 and out_err=1; the word is still handshaked.
REQ-031 SHALL increment enc_count or err_count only on an output transfer.

Reset
REQ-032 SHALL, on rst, set out_valid=0, out_instr=0, out_err=0, enc_count=0 and err_count=0, with in_ready=1 on the following cycle.
REQ-033 SHALL, on rst asserted mid-stall, discard the pending word without counting it.
REQ-034 SHALL, while rst is high, accept no request.

Configuration
REQ-035 SHALL, with INSTR_ENC_CTRLFLOW_EN defined, encode BRANCH, JAL and JALR; without it, kinds 4-6 SHALL be illegal (out_err=1) and the B/J immediate logic SHALL be absent.

Verification
REQ-036 SHALL verify: R, alu_op 0000, rd=3, rs1=1, rs2=2 -> next cycle out_instr=0x002081B3, out_err=0.
REQ-037 SHALL verify: R, alu_op 0001, rd=5, rs1=6, rs2=7 -> 0x407302B3; I-ALU, alu_op 0000, rd=1, rs1=0, imm=-1 -> 0xFFF00093.
REQ-038 SHALL verify: LOAD, rd=4, rs1=2, imm=8 -> 0x00812203; I-ALU with imm=2048 -> out_instr=0, out_err=1, err_count=1.
REQ-039 SHALL verify, with the macro defined: BRANCH, in_f3=000, rs1=1, rs2=2, imm=8 -> 0x00208463; imm=7 -> out_err=1.
REQ-040 SHALL verify backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_instr stable; then release -> 2 words transferred in 2 cycles and enc_count=2.
REQ-041 SHALL verify: rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0 and enc_count=0.
